// File: rtl/packet_disassembler.sv
// HDMI data island packet receiver: rebuilds the BCH header block and four
// subpacket blocks from 9-bit symbols and flags per-block ECC mismatches.
module packet_disassembler (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        data_island_period,
  input  logic [8:0]  packet_data,
  output logic [23:0] header,
  output logic [55:0] sub [3:0],
  output logic [4:0]  ecc_error,
  output logic        packet_valid,
  output logic [4:0]  counter
);

  localparam logic [7:0] BCH_POLY = 8'h83;

  function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
    ecc_step = {1'b0, e[7:1]} ^ ((e[0] ^ b) ? BCH_POLY : 8'h00);
  endfunction

  logic first_sym;
  logic last_sym;
  logic clear_work;

  assign first_sym  = (counter == 5'd0);
  assign last_sym   = (counter == 5'd31);
  assign clear_work = reset || !data_island_period || last_sym;

  // Position 0 always starts from a zero seed, so the wrap cycle after a
  // completion never loses its bits to the pending clear.
  logic [31:0] hbuf_reg;
  logic [31:0] hbuf_base;
  logic [31:0] hbuf_next;
  logic [7:0]  hecc_reg;
  logic [7:0]  hecc_base;
  logic [7:0]  hecc_next;
  logic        hdr_err;

  always_comb begin
    hbuf_base          = first_sym ? 32'd0 : hbuf_reg;
    hecc_base          = first_sym ? 8'd0  : hecc_reg;
    hbuf_next          = hbuf_base;
    hbuf_next[counter] = packet_data[0];
    hecc_next          = (counter < 5'd24) ? ecc_step(hecc_base, packet_data[0]) : hecc_base;
  end

  assign hdr_err = (hecc_next != hbuf_next[31:24]);

  always_ff @(posedge clk_pixel) begin
    if (clear_work) begin
      hbuf_reg <= 32'd0;
      hecc_reg <= 8'd0;
    end else begin
      hbuf_reg <= hbuf_next;
      hecc_reg <= hecc_next;
    end
  end

  logic [3:0][55:0] sub_data_next;
  logic [3:0]       sub_err;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sub
      logic [63:0] buf_reg;
      logic [63:0] buf_base;
      logic [63:0] buf_next;
      logic [7:0]  ecc_reg;
      logic [7:0]  ecc_base;
      logic [7:0]  ecc_mid;
      logic [7:0]  ecc_next;
      logic        bit_lo;
      logic        bit_hi;

      assign bit_lo = packet_data[1 + gi];
      assign bit_hi = packet_data[5 + gi];

      // Two generator steps per symbol: bit 2c first, then bit 2c+1.
      always_comb begin
        buf_base                    = first_sym ? 64'd0 : buf_reg;
        ecc_base                    = first_sym ? 8'd0  : ecc_reg;
        buf_next                    = buf_base;
        buf_next[{counter, 1'b0}]   = bit_lo;
        buf_next[{counter, 1'b1}]   = bit_hi;
        ecc_mid                     = ecc_step(ecc_base, bit_lo);
        ecc_next                    = (counter < 5'd28) ? ecc_step(ecc_mid, bit_hi) : ecc_base;
      end

      always_ff @(posedge clk_pixel) begin
        if (clear_work) begin
          buf_reg <= 64'd0;
          ecc_reg <= 8'd0;
        end else begin
          buf_reg <= buf_next;
          ecc_reg <= ecc_next;
        end
      end

      assign sub_data_next[gi] = buf_next[55:0];
      assign sub_err[gi]       = (ecc_next != buf_next[63:56]);
    end
  endgenerate

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      counter      <= 5'd0;
      header       <= 24'd0;
      ecc_error    <= 5'd0;
      packet_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sub[i] <= 56'd0;
      end
    end else begin
      packet_valid <= 1'b0;
      if (!data_island_period) begin
        counter <= 5'd0;
      end else begin
        counter <= counter + 5'd1;
        if (last_sym) begin
          header       <= hbuf_next[23:0];
          ecc_error    <= {hdr_err, sub_err};
          packet_valid <= 1'b1;
          for (int i = 0; i < 4; i++) begin
            sub[i] <= sub_data_next[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_packet_disassembler.sv
// Scoreboard bench for packet_disassembler: serializes packets with a
// reference BCH model and checks each delivered packet.
module tb_packet_disassembler;

  logic        clk_pixel = 1'b0;
  logic        reset;
  logic        data_island_period;
  logic [8:0]  packet_data;
  logic [23:0] header;
  logic [55:0] sub [3:0];
  logic [4:0]  ecc_error;
  logic        packet_valid;
  logic [4:0]  counter;

  packet_disassembler dut (
    .clk_pixel          (clk_pixel),
    .reset              (reset),
    .data_island_period (data_island_period),
    .packet_data        (packet_data),
    .header             (header),
    .sub                (sub),
    .ecc_error          (ecc_error),
    .packet_valid       (packet_valid),
    .counter            (counter)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    logic [23:0]      h;
    logic [3:0][55:0] s;
    logic [4:0]       e;
    int               due;
  } exp_t;

  exp_t scoreboard[$];
  exp_t mon_x;
  int checks = 0;
  int passed = 0;
  int cycle = 0;
  int pulses = 0;
  int pulse_prev = 0;
  int pulse_last = 0;

  always @(posedge clk_pixel) cycle <= cycle + 1;

  function automatic logic [7:0] bch(input logic [63:0] d, input int n);
    logic [7:0] e;
    e = 8'h00;
    for (int i = 0; i < n; i++) begin
      e = {1'b0, e[7:1]} ^ ((e[0] ^ d[i]) ? 8'h83 : 8'h00);
    end
    return e;
  endfunction

  // Consumer side of the scoreboard: every pulse pops one expected packet.
  always @(negedge clk_pixel) begin
    if (packet_valid === 1'b1) begin
      pulses++;
      pulse_prev = pulse_last;
      pulse_last = cycle;
      checks++;
      if (scoreboard.size() == 0) begin
        $display("FAIL unexpected_pulse: got pulse at cycle %0d, required none", cycle);
      end else begin
        passed++;
        mon_x = scoreboard.pop_front();
        checks++;
        if (cycle !== mon_x.due) $display("FAIL latency: got cycle %0d, required %0d", cycle, mon_x.due);
        else passed++;
        checks++;
        if (header !== mon_x.h) $display("FAIL header: got %h, required %h", header, mon_x.h);
        else passed++;
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (sub[i] !== mon_x.s[i]) $display("FAIL sub%0d: got %h, required %h", i, sub[i], mon_x.s[i]);
          else passed++;
        end
        checks++;
        if (ecc_error !== mon_x.e) $display("FAIL ecc_error: got %b, required %b", ecc_error, mon_x.e);
        else passed++;
        $display("packet at cycle %0d: header=%h ecc_error=%b", cycle, header, ecc_error);
      end
    end
  end

  task automatic send_packet(input logic [23:0] h, input logic [3:0][55:0] s,
                             input int flip_c, input int flip_b,
                             input logic [4:0] exp_e, input int stop_at);
    logic [31:0]      hb;
    logic [3:0][63:0] blk;
    logic [8:0]       sym;
    exp_t             x;
    hb = {bch({40'd0, h}, 24), h};
    for (int i = 0; i < 4; i++) blk[i] = {bch({8'd0, s[i]}, 56), s[i]};
    for (int c = 0; c < 32; c++) begin
      @(negedge clk_pixel);
      if (c == stop_at) begin
        checks++;
        if (counter !== c[4:0]) $display("FAIL counter_at_stop: got %0d, required %0d", counter, c);
        else passed++;
        data_island_period = 1'b0;
        packet_data = 9'd0;
        return;
      end
      sym[0] = hb[c];
      for (int i = 0; i < 4; i++) begin
        sym[1 + i] = blk[i][2 * c];
        sym[5 + i] = blk[i][2 * c + 1];
      end
      if (c == flip_c) sym[flip_b] = ~sym[flip_b];
      if (c == 31) begin
        x.h = h; x.s = s; x.e = exp_e; x.due = cycle + 1;
        scoreboard.push_back(x);
      end
      data_island_period = 1'b1;
      packet_data = sym;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_pixel);
      data_island_period = 1'b0;
      packet_data = 9'd0;
    end
  endtask

  task automatic check_drained(input string name, input int pulses_before, input int want);
    checks++;
    if (scoreboard.size() != 0 || pulses - pulses_before != want)
      $display("FAIL %s_drain: got %0d pulses/%0d pending, required %0d/0",
               name, pulses - pulses_before, scoreboard.size(), want);
    else passed++;
  endtask

  logic [3:0][55:0] s_zero, s_known, s_alt, s_third;

  task automatic check_zero_outputs(input string name);
    checks++;
    if (header !== 24'd0 || ecc_error !== 5'd0 || packet_valid !== 1'b0 || counter !== 5'd0 ||
        sub[0] !== 56'd0 || sub[1] !== 56'd0 || sub[2] !== 56'd0 || sub[3] !== 56'd0)
      $display("FAIL %s: got header=%h ecc=%b valid=%b counter=%0d sub0=%h, required all zero",
               name, header, ecc_error, packet_valid, counter, sub[0]);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_pixel);
    check_zero_outputs("reset_state");
    reset = 1'b0;
    $display("reset state checked");
  endtask

  task automatic test_all_zero();
    int p0 = pulses;
    send_packet(24'd0, s_zero, -1, 0, 5'b00000, -1);
    idle(3);
    check_drained("all_zero", p0, 1);
  endtask

  task automatic test_known_packet();
    int p0 = pulses;
    send_packet(24'h0D0282, s_known, -1, 0, 5'b00000, -1);
    idle(3);
    check_drained("known", p0, 1);
  endtask

  task automatic test_parity_error();
    int p0 = pulses;
    send_packet(24'h0D0282, s_known, 29, 7, 5'b00100, -1);
    idle(3);
    check_drained("parity_error", p0, 1);
  endtask

  task automatic test_back_to_back();
    int p0 = pulses;
    send_packet(24'h123456, s_alt, -1, 0, 5'b00000, -1);
    send_packet(24'hA5C3F0, s_third, -1, 0, 5'b00000, -1);
    idle(3);
    check_drained("back_to_back", p0, 2);
    checks++;
    if (pulse_last - pulse_prev != 32)
      $display("FAIL b2b_spacing: got %0d cycles, required 32", pulse_last - pulse_prev);
    else passed++;
  endtask

  task automatic test_abort();
    int p0 = pulses;
    send_packet(24'h777777, s_known, -1, 0, 5'b00000, 17);
    idle(3);
    checks++;
    if (header !== 24'hA5C3F0 || sub[0] !== s_third[0] || ecc_error !== 5'd0 || counter !== 5'd0)
      $display("FAIL abort_hold: got header=%h sub0=%h ecc=%b counter=%0d, required %h %h 0 0",
               header, sub[0], ecc_error, counter, 24'hA5C3F0, s_third[0]);
    else passed++;
    check_drained("abort_partial", p0, 0);
    send_packet(24'h0D0282, s_alt, -1, 0, 5'b00000, -1);
    idle(3);
    check_drained("abort_recover", p0, 1);
  endtask

  task automatic test_reset_mid();
    int p0 = pulses;
    send_packet(24'hBEEF01, s_third, -1, 0, 5'b00000, 10);
    reset = 1'b1;
    data_island_period = 1'b1;
    @(negedge clk_pixel);
    check_zero_outputs("reset_mid_1");
    @(negedge clk_pixel);
    check_zero_outputs("reset_mid_2");
    reset = 1'b0;
    data_island_period = 1'b0;
    @(negedge clk_pixel);
    check_zero_outputs("after_reset");
    send_packet(24'h0D0282, s_known, -1, 0, 5'b00000, -1);
    idle(3);
    check_drained("reset_mid", p0, 1);
  endtask

  initial begin
    reset = 1'b1;
    data_island_period = 1'b0;
    packet_data = 9'd0;
    s_zero = '0;
    s_known[0] = 56'h0123456789ABCD;
    s_known[1] = 56'hFEDCBA98765432;
    s_known[2] = 56'h00000000000001;
    s_known[3] = 56'hFFFFFFFFFFFFFF;
    s_alt[0]   = 56'h11223344556677;
    s_alt[1]   = 56'h8899AABBCCDDEE;
    s_alt[2]   = 56'h0F0F0F0F0F0F0F;
    s_alt[3]   = 56'h80000000000000;
    s_third[0] = 56'hDEADBEEFCAFE12;
    s_third[1] = 56'h00FF00FF00FF00;
    s_third[2] = 56'h13579BDF2468AC;
    s_third[3] = 56'h00000000000000;
    test_reset();
    test_all_zero();
    test_known_packet();
    test_parity_error();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
